commit_trace_buffer: RTL

- Synthesisable trace capture block that records retired-instruction commits (PC, instruction word, sequence number) from a core's MEM-stage commit port into an on-chip FIFO.
- Capture can start immediately or on a PC trigger, lasts for a programmed post-trigger window, and can keep pre-trigger history in wrap mode.
- Sits beside core0 on MotherBoard. A debug master or testbench drains it through a valid/ready read port.

---
 rtl/commit_trace_buffer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired-instruction commits into a fall-through FIFO.
// Define TRACE_TIMESTAMP_EN to add a per-entry cycle timestamp and the o_rd_ts port.
module commit_trace_buffer #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned SEQ_W  = 16,
   parameter int unsigned TS_W   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_arm,
   input  logic                     i_mode,
   input  logic                     i_trig_en,
   input  logic [ADDR_W-1:0]        i_trig_pc,
   input  logic [CNT_W-1:0]         i_post_cnt,
   input  logic                     i_commit_valid,
   input  logic [ADDR_W-1:0]        i_commit_pc,
   input  logic [DATA_W-1:0]        i_commit_instr,
   output logic                     o_rd_valid,
   input  logic                     i_rd_ready,
   output logic [ADDR_W-1:0]        o_rd_pc,
   output logic [DATA_W-1:0]        o_rd_instr,
   output logic [SEQ_W-1:0]         o_rd_seq,
   output logic [1:0]               o_state,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]          o_rd_ts
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = PTR_W + 1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } state_e;

   state_e            state_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              overflow_q;
   logic [SEQ_W-1:0]  seq_q;
   logic [CNT_W-1:0]  remain_q;

   logic [ADDR_W-1:0] mem_pc    [DEPTH];
   logic [DATA_W-1:0] mem_instr [DEPTH];
   logic [SEQ_W-1:0]  mem_seq   [DEPTH];

   logic             active;
   logic             commit;
   logic             is_trig;
   logic             want_push;
   logic             empty;
   logic             full;
   logic             pop;
   logic             wr_en;
   logic             lost;
   logic             rd_adv;
   logic [CNT_W-1:0] post_m1;

   always_comb begin
      active    = (state_q == StArmed) || (state_q == StCapture);
      commit    = i_commit_valid && active && !i_arm;
      is_trig   = !i_trig_en || (i_commit_pc == i_trig_pc);
      // Pre-trigger commits are only kept as history in wrap mode.
      want_push = commit && ((state_q == StCapture) || is_trig || i_mode);
      empty     = (count_q == '0);
      full      = (count_q == CW'(DEPTH));
      pop       = !empty && i_rd_ready;
      wr_en     = want_push && (!full || pop || i_mode);
      lost      = want_push && full && !pop;
      // Overwrite in wrap mode retires the oldest entry without a pop.
      rd_adv    = pop || (lost && i_mode);
      post_m1   = (i_post_cnt == '0) ? '0 : i_post_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         seq_q      <= '0;
         remain_q   <= '0;
      end else if (i_arm) begin
         state_q    <= StArmed;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         seq_q      <= '0;
         remain_q   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_adv) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CW'(wr_en) - CW'(rd_adv);
         if (lost) begin
            overflow_q <= 1'b1;
         end
         if (commit) begin
            seq_q <= seq_q + SEQ_W'(1);
            if (state_q == StArmed) begin
               if (is_trig) begin
                  remain_q <= post_m1;
                  state_q  <= (post_m1 == '0) ? StDone : StCapture;
               end
            end else begin
               // The window counts dropped commits as well as stored ones.
               remain_q <= remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) begin
                  state_q <= StDone;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr_q]    <= i_commit_pc;
         mem_instr[wr_ptr_q] <= i_commit_instr;
         mem_seq[wr_ptr_q]   <= seq_q;
      end
   end

   assign o_rd_valid = !empty;
   assign o_rd_pc    = empty ? '0 : mem_pc[rd_ptr_q];
   assign o_rd_instr = empty ? '0 : mem_instr[rd_ptr_q];
   assign o_rd_seq   = empty ? '0 : mem_seq[rd_ptr_q];
   assign o_state    = state_q;
   assign o_count    = count_q;
   assign o_overflow = overflow_q;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] mem_ts [DEPTH];

   // Free-running; deliberately not cleared by i_arm.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_ts[wr_ptr_q] <= ts_q;
      end
   end

   assign o_rd_ts = empty ? '0 : mem_ts[rd_ptr_q];
`else
   logic unused_ts_w;
   assign unused_ts_w = ^TS_W;
`endif

endmodule
